uart_tx_arb: RTL and testbench

Round-robin arbiter that shares a single `uart_tx` byte transmitter among `N_REQ` independent byte producers. It sits directly in front of `uart_tx`. It accepts one byte at a time from the winning requester over a valid/ready handshake, issues it to the transmitter as a one-cycle `wr_enb` pulse, and tracks the transmitter's `busy` through the whole frame before granting again. An optional inter-frame guard gap, counted in baud ticks, can be compiled in.

---
 rtl/uart_tx_arb.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx byte transmitter
// among N_REQ byte producers. One byte per frame is accepted over a
// valid/ready handshake, issued as a one-cycle tx_wr_enb, and the
// transmitter's busy is tracked through the frame before the next grant.
// Optional inter-frame guard gap (in baud ticks): define UART_TX_ARB_GAP_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | arbitrate; accept winner's byte when tx_busy is low
// ISSUE     | tx_wr_enb high for this one cycle
// WAIT_BUSY | wait up to 4 cycles for tx_busy to rise, else pulse err
// WAIT_DONE | wait for tx_busy to fall (end of frame)
// GAP       | (gap build only) count GAP_TICKS enb ticks of idle line
module uart_tx_arb #(
  parameter int N_REQ     = 4,
  parameter int GAP_TICKS = 2
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [N_REQ-1:0]                            req_valid,
  input  logic [8*N_REQ-1:0]                          req_data,
  output logic [N_REQ-1:0]                            req_ready,
  input  logic                                        enb,
  output logic                                        tx_wr_enb,
  output logic [7:0]                                  tx_data,
  input  logic                                        tx_busy,
  output logic [$clog2((N_REQ > 2) ? N_REQ : 2)-1:0] grant_id,
  output logic                                        active,
  output logic                                        err
);

  localparam int IW = $clog2((N_REQ > 2) ? N_REQ : 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3
`ifdef UART_TX_ARB_GAP_EN
    , GAP     = 3'd4
`endif
  } state_t;

  state_t        state, state_d;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] win_idx;
  logic [7:0]    win_data;
  logic          found;
  logic          accept;
  logic          err_d;
  logic [1:0]    tmo_cnt, tmo_d;
  int            rr_idx;

`ifdef UART_TX_ARB_GAP_EN
  logic [3:0]    gap_cnt, gap_d;
`else
  logic          unused_enb;
  assign unused_enb = enb;
`endif

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    rr_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (int'(last_grant) + 1 + k) % N_REQ;
      if (!found && req_valid[rr_idx]) begin
        found    = 1'b1;
        win_idx  = IW'(rr_idx);
        win_data = req_data[8*rr_idx +: 8];
      end
    end
  end

  // Acceptance strobe: one-hot, only in IDLE with the transmitter free.
  always_comb begin
    accept    = (state == IDLE) && !tx_busy && found && !reset;
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  // Next-state logic; timers are down-counters ending at terminal count.
  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    tmo_d   = tmo_cnt;
`ifdef UART_TX_ARB_GAP_EN
    gap_d   = gap_cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
        tmo_d   = 2'd3;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
          tmo_d   = 2'd0;
        end else if (tmo_cnt == 2'd0) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_cnt - 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
`ifdef UART_TX_ARB_GAP_EN
          state_d = GAP;
          gap_d   = 4'(GAP_TICKS);
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_TX_ARB_GAP_EN
      GAP: begin
        if (enb) begin
          if (gap_cnt == 4'd1) begin
            state_d = IDLE;
            gap_d   = 4'd0;
          end else begin
            gap_d = gap_cnt - 4'd1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= 2'd0;
`ifdef UART_TX_ARB_GAP_EN
      gap_cnt <= 4'd0;
`endif
    end else begin
      state   <= state_d;
      tmo_cnt <= tmo_d;
`ifdef UART_TX_ARB_GAP_EN
      gap_cnt <= gap_d;
`endif
    end
  end

  // Registered outputs and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_enb  <= 1'b0;
      tx_data    <= 8'h00;
      grant_id   <= '0;
      last_grant <= IW'(N_REQ - 1);
      active     <= 1'b0;
      err        <= 1'b0;
    end else begin
      tx_wr_enb <= accept;
      active    <= (state_d != IDLE);
      err       <= err_d;
      if (accept) begin
        tx_data    <= win_data;
        grant_id   <= win_idx;
        last_grant <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: behavioural uart_tx model plus directed and
// randomized scenarios checked against a round-robin reference model.
module tb_uart_tx_arb;

  localparam int N    = 4;
  localparam int GAPT = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           enb = 1'b0;
  logic           tx_wr_enb;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           active;
  logic           err;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic       busy_tie0 = 1'b0;
  int         frame_len = 4;
  int         busy_left = 0;
  logic [7:0] sent_q[$];

  uart_tx_arb #(.N_REQ(N), .GAP_TICKS(GAPT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enb(enb), .tx_wr_enb(tx_wr_enb), .tx_data(tx_data),
    .tx_busy(tx_busy), .grant_id(grant_id), .active(active), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // baud tick every third cycle
  always @(negedge clk) enb = (cyc % 3 == 0);

  // uart_tx stand-in: busy for frame_len cycles starting two cycles after acceptance
  always @(posedge clk) begin
    if (reset) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (busy_tie0) begin
      tx_busy <= 1'b0;
    end else if (tx_wr_enb && !tx_busy) begin
      tx_busy   <= 1'b1;
      busy_left <= frame_len;
      sent_q.push_back(tx_data);
    end else if (tx_busy) begin
      if (busy_left <= 1) tx_busy <= 1'b0;
      busy_left <= busy_left - 1;
    end
  end

  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_data = '0; busy_tie0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (!active && !tx_busy) done = 1;
    end
    vecs++;
    if (!done) begin
      errs++;
      $display("FAIL wait_idle: got timeout, expected return to IDLE within 300 cycles");
    end
  endtask

  task automatic test_reset();
    logic [7:0] d0;
    @(negedge clk);
    reset = 1'b1; req_valid = '1; req_data = {$urandom};
    d0 = req_data[7:0];
    @(negedge clk); #1;
    vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL rst_req_ready: got %b expected 0000", req_ready); end
    vecs++; if (tx_wr_enb !== 1'b0) begin errs++; $display("FAIL rst_tx_wr_enb: got %b expected 0", tx_wr_enb); end
    vecs++; if (tx_data !== 8'h00) begin errs++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL rst_grant_id: got %0d expected 0", grant_id); end
    vecs++; if (active !== 1'b0) begin errs++; $display("FAIL rst_active: got %b expected 0", active); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL rst_err: got %b expected 0", err); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL first_grant: got %b expected 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    vecs++; if (tx_wr_enb !== 1'b1) begin errs++; $display("FAIL first_wr_enb: got %b expected 1", tx_wr_enb); end
    vecs++; if (tx_data !== d0) begin errs++; $display("FAIL first_tx_data: got %h expected %h", tx_data, d0); end
    vecs++; if (active !== 1'b1) begin errs++; $display("FAIL first_active: got %b expected 1", active); end
    @(negedge clk); #1;
    vecs++; if (tx_wr_enb !== 1'b0) begin errs++; $display("FAIL wr_enb_one_cycle: got %b expected 0", tx_wr_enb); end
    wait_idle();
  endtask

  task automatic test_round_robin();
    int rdy_ids[$];
    int gids[$];
    do_reset();
    sent_q.delete();
    frame_len = 4;
    req_valid = '1;
    req_data  = 32'hA3A2A1A0;
    for (int c = 0; c < 400 && gids.size() < 5; c++) begin
      #1;
      if (req_ready != '0) rdy_ids.push_back(onehot_idx(req_ready));
      if (tx_wr_enb) gids.push_back(int'(grant_id));
      @(negedge clk);
      if (rdy_ids.size() >= 5) req_valid = '0;
    end
    req_valid = '0;
    wait_idle();
    vecs++; if (gids.size() != 5 || sent_q.size() != 5) begin errs++; $display("FAIL rr_count: got %0d grants %0d bytes expected 5 and 5", gids.size(), sent_q.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < gids.size()) begin
        vecs++; if (gids[k] != k % 4) begin errs++; $display("FAIL rr_grant_id[%0d]: got %0d expected %0d", k, gids[k], k % 4); end
      end
      if (k < rdy_ids.size()) begin
        vecs++; if (rdy_ids[k] != k % 4) begin errs++; $display("FAIL rr_ready[%0d]: got %0d expected %0d", k, rdy_ids[k], k % 4); end
      end
      if (k < sent_q.size()) begin
        vecs++; if (sent_q[k] !== 8'(8'hA0 + k % 4)) begin errs++; $display("FAIL rr_byte[%0d]: got %h expected %h", k, sent_q[k], 8'(8'hA0 + k % 4)); end
      end
    end
  endtask

  task automatic test_sparse();
    int ids[$];
    bit bad = 0;
    int exp_ids[3] = '{1, 3, 1};
    do_reset();
    frame_len = 3;
    req_valid = 4'b1010;
    req_data  = {$urandom};
    for (int c = 0; c < 300 && ids.size() < 3; c++) begin
      #1;
      if (req_ready[0] || req_ready[2]) bad = 1;
      if (req_ready != '0) ids.push_back(onehot_idx(req_ready));
      @(negedge clk);
      if (ids.size() >= 3) req_valid = '0;
    end
    req_valid = '0;
    wait_idle();
    vecs++; if (bad) begin errs++; $display("FAIL sparse_ready02: got assertion of ready[0] or ready[2], expected none"); end
    vecs++; if (ids.size() != 3) begin errs++; $display("FAIL sparse_count: got %0d expected 3", ids.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < ids.size()) begin
        vecs++; if (ids[k] != exp_ids[k]) begin errs++; $display("FAIL sparse_grant[%0d]: got %0d expected %0d", k, ids[k], exp_ids[k]); end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    busy_tie0 = 1'b1;
    req_valid = 4'b0001;
    req_data  = {$urandom};
    #1;
    vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL tmo_accept: got %b expected 0001", req_ready); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      vecs++; if (err !== (k == 6)) begin errs++; $display("FAIL tmo_err@+%0d: got %b expected %b", k, err, (k == 6)); end
      if (k == 6) begin
        vecs++; if (active !== 1'b0) begin errs++; $display("FAIL tmo_idle: got active %b expected 0", active); end
      end
    end
    busy_tie0 = 1'b0;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL tmo_recover: got %b expected 0100", req_ready); end
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    frame_len = 6;
    req_valid = 4'b0010;
    req_data  = 32'h11223344;
    #1;
    vecs++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL mid_accept: got %b expected 0010", req_ready); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      if (tx_busy) break;
    end
    @(negedge clk); #1;
    vecs++; if (active !== 1'b1 || tx_busy !== 1'b1) begin errs++; $display("FAIL mid_in_frame: got active %b busy %b expected 1 1", active, tx_busy); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++; if (tx_wr_enb !== 1'b0) begin errs++; $display("FAIL mid_wr_enb: got %b expected 0", tx_wr_enb); end
    vecs++; if (tx_data !== 8'h00) begin errs++; $display("FAIL mid_tx_data: got %h expected 00", tx_data); end
    vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL mid_grant_id: got %0d expected 0", grant_id); end
    vecs++; if (active !== 1'b0) begin errs++; $display("FAIL mid_active: got %b expected 0", active); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL mid_err: got %b expected 0", err); end
    vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL mid_req_ready: got %b expected 0000", req_ready); end
    @(negedge clk);
    req_valid = '1;
    #1;
    vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_fresh_grant: got %b expected 0001", req_ready); end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int         model_last = N - 1;
    int         earliest;
    int         acc_cyc = -10;
    int         exp_id = 0;
    logic [7:0] exp_byte = 8'h00;
    logic [N-1:0] exp_ready;
    bit         prev_busy = 0;
    int         fall_cyc = 0;
    int         ticks = 0;
    bit         counting = 0;
    do_reset();
    earliest = cyc;
    for (int c = 0; c < 600; c++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      req_data  = {$urandom};
      frame_len = $urandom_range(2, 6);
      #1;
      if (counting && cyc > fall_cyc && enb) begin
        ticks++;
        if (ticks == GAPT) begin
          earliest = cyc + 1;
          counting = 0;
        end
      end
      if (prev_busy && !tx_busy) begin
        fall_cyc = cyc;
`ifdef UART_TX_ARB_GAP_EN
        ticks    = 0;
        counting = 1;
`else
        earliest = cyc + 1;
`endif
      end
      prev_busy = tx_busy;
      exp_ready = '0;
      if (cyc >= earliest && req_valid != '0) begin
        exp_id    = rr_pick(model_last, req_valid);
        exp_ready[exp_id] = 1'b1;
        exp_byte  = req_data[8*exp_id +: 8];
        model_last = exp_id;
        acc_cyc   = cyc;
        earliest  = 32'h7fffffff;
      end
      vecs++; if (req_ready !== exp_ready) begin errs++; $display("FAIL b2b_ready@%0d: got %b expected %b", cyc, req_ready, exp_ready); end
      vecs++; if (tx_wr_enb !== (cyc == acc_cyc + 1)) begin errs++; $display("FAIL b2b_wr_enb@%0d: got %b expected %b", cyc, tx_wr_enb, (cyc == acc_cyc + 1)); end
      if (cyc == acc_cyc + 1) begin
        vecs++; if (tx_data !== exp_byte) begin errs++; $display("FAIL b2b_tx_data@%0d: got %h expected %h", cyc, tx_data, exp_byte); end
        vecs++; if (int'(grant_id) != exp_id) begin errs++; $display("FAIL b2b_grant_id@%0d: got %0d expected %0d", cyc, grant_id, exp_id); end
      end
      @(negedge clk);
    end
    req_valid = '0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_sparse();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
